// File: rtl/ysyx_22041461_idu_stage.sv
// Registered RV32I/RV64I decode stage between IFU and EXU.
// One instruction per valid/ready handshake; flush and reset drop the held bundle.
module ysyx_22041461_idu_stage #(
   parameter int XLEN = 64,
   parameter int PC_W = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic            out_en_regw,
   output logic            out_is_ebreak,
   output logic            out_illegal
);

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

   localparam logic [6:0]  OPC_OP     = 7'b0110011;
   localparam logic [6:0]  OPC_OP32   = 7'b0111011;
   localparam logic [6:0]  OPC_IMM    = 7'b0010011;
   localparam logic [6:0]  OPC_IMM32  = 7'b0011011;
   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_LUI    = 7'b0110111;
   localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
   localparam logic [31:0] EBREAK     = 32'h0010_0073;
   localparam logic        RV32_ONLY  = (XLEN == 32);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rd;
   fmt_e            fmt;
   logic            illegal;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_d;
   logic            en_regw_d;
   logic            capture;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign rd     = in_inst[11:7];

   always_comb begin
      fmt     = FMT_NONE;
      illegal = 1'b0;
      case (opcode)
         OPC_OP:                       fmt = FMT_R;
         OPC_OP32: begin
            fmt     = FMT_R;
            illegal = RV32_ONLY;
         end
         OPC_IMM, OPC_LOAD, OPC_JALR:  fmt = FMT_I;
         OPC_IMM32: begin
            fmt     = FMT_I;
            illegal = RV32_ONLY;
         end
         OPC_STORE:                    fmt = FMT_S;
         OPC_BRANCH: begin
            fmt     = FMT_B;
            illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_LUI, OPC_AUIPC:           fmt = FMT_U;
         OPC_JAL:                      fmt = FMT_J;
         OPC_SYSTEM:                   illegal = (in_inst != EBREAK);
         default:                      illegal = 1'b1;
      endcase
   end

   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
         FMT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         FMT_B:   imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         FMT_U:   imm32 = {in_inst[31:12], 12'b0};
         FMT_J:   imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // imm32 is already sign-extended to 32 bits; the signed size cast carries bit 31 up to XLEN.
   assign imm_d     = illegal ? '0 : XLEN'(signed'(imm32));
   assign en_regw_d = !illegal && (rd != 5'd0) && (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J});

   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_pc        <= '0;
         out_rs1       <= '0;
         out_rs2       <= '0;
         out_rd        <= '0;
         out_imm       <= '0;
         out_fmt       <= '0;
         out_opcode    <= '0;
         out_funct3    <= '0;
         out_funct7    <= '0;
         out_en_regw   <= 1'b0;
         out_is_ebreak <= 1'b0;
         out_illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid     <= 1'b1;
         out_pc        <= in_pc;
         out_rs1       <= in_inst[19:15];
         out_rs2       <= in_inst[24:20];
         out_rd        <= rd;
         out_imm       <= imm_d;
         out_fmt       <= fmt;
         out_opcode    <= opcode;
         out_funct3    <= funct3;
         out_funct7    <= in_inst[31:25];
         out_en_regw   <= en_regw_d;
         out_is_ebreak <= (in_inst == EBREAK);
         out_illegal   <= illegal;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ysyx_22041461_idu_stage.sv
// Scoreboard bench for ysyx_22041461_idu_stage: driver pushes expected bundles on capture,
// monitors compare whenever the DUT presents out_valid.
module tb_ysyx_22041461_idu_stage;

   typedef struct {
      logic [63:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        en, eb, ill;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      exp_t        e;
   } vec_t;

   typedef struct {
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        en, ill;
   } exp32_t;

   logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, out_pc, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [2:0]  out_fmt, out_funct3;
   logic [6:0]  out_opcode, out_funct7;
   logic        out_en_regw, out_is_ebreak, out_illegal;

   logic        i32_valid, i32_ready, o32_valid;
   logic [31:0] i32_inst, i32_pc, o32_pc, o32_imm;
   logic [4:0]  o32_rs1, o32_rs2, o32_rd;
   logic [2:0]  o32_fmt, o32_funct3;
   logic [6:0]  o32_opcode, o32_funct7;
   logic        o32_en_regw, o32_is_ebreak, o32_illegal;

   int errors = 0;
   int checks = 0;
   exp_t   q[$];
   exp32_t q32[$];
   vec_t   vec[12];
   logic        m_valid = 1'b0;
   logic [63:0] pc_next = 64'h8000_0000;

   ysyx_22041461_idu_stage #(.XLEN(64), .PC_W(64)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_opcode(out_opcode), .out_funct3(out_funct3),
      .out_funct7(out_funct7), .out_en_regw(out_en_regw),
      .out_is_ebreak(out_is_ebreak), .out_illegal(out_illegal)
   );

   ysyx_22041461_idu_stage #(.XLEN(32), .PC_W(32)) u_dut32 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(i32_valid), .in_ready(i32_ready), .in_inst(i32_inst), .in_pc(i32_pc),
      .out_valid(o32_valid), .out_ready(1'b1), .out_pc(o32_pc),
      .out_rs1(o32_rs1), .out_rs2(o32_rs2), .out_rd(o32_rd), .out_imm(o32_imm),
      .out_fmt(o32_fmt), .out_opcode(o32_opcode), .out_funct3(o32_funct3),
      .out_funct7(o32_funct7), .out_en_regw(o32_en_regw),
      .out_is_ebreak(o32_is_ebreak), .out_illegal(o32_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic setv(input int i, input logic [31:0] inst, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] imm,
                       input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic en, input logic eb, input logic ill);
      vec[i].inst  = inst;
      vec[i].e.pc  = '0;
      vec[i].e.rs1 = rs1;  vec[i].e.rs2 = rs2; vec[i].e.rd = rd;
      vec[i].e.imm = imm;  vec[i].e.fmt = fmt; vec[i].e.op = op;
      vec[i].e.f3  = f3;   vec[i].e.f7  = f7;
      vec[i].e.en  = en;   vec[i].e.eb  = eb;  vec[i].e.ill = ill;
   endtask

   // One bench cycle: drive, then just after the falling edge (monitor already ran) check
   // handshake signals against the bench's own valid model and update the scoreboard.
   task automatic drive_cycle(input logic iv, input int idx, input logic ordy,
                              input logic fl, input logic r, output logic cap);
      exp_t e;
      in_valid  = iv;
      in_inst   = vec[idx].inst;
      in_pc     = pc_next;
      out_ready = ordy;
      flush     = fl;
      rst       = r;
      @(negedge clk);
      #1;
      chk("in_ready", 256'(in_ready), 256'(!m_valid || ordy));
      chk("out_valid", 256'(out_valid), 256'(m_valid));
      cap = !r && !fl && iv && (!m_valid || ordy);
      if (r) begin
         q.delete();
         m_valid = 1'b0;
      end else begin
         if (fl && m_valid && !ordy && q.size() > 0) void'(q.pop_front());
         if (cap) begin
            e    = vec[idx].e;
            e.pc = pc_next;
            q.push_back(e);
         end
         if (fl)                  m_valid = 1'b0;
         else if (cap)            m_valid = 1'b1;
         else if (m_valid && ordy) m_valid = 1'b0;
      end
      if (cap) pc_next = pc_next + 64'd4;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state();
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_in_ready", 256'(in_ready), 256'(1));
      chk("rst_fields", 256'({out_pc, out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_opcode,
                              out_funct3, out_funct7, out_en_regw, out_is_ebreak, out_illegal}),
          256'(0));
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            chk("spurious_valid", 256'(out_valid), 256'(0));
         end else begin
            chk("bundle",
                256'({out_pc, out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_opcode,
                      out_funct3, out_funct7, out_en_regw, out_is_ebreak, out_illegal}),
                256'({q[0].pc, q[0].rs1, q[0].rs2, q[0].rd, q[0].imm, q[0].fmt, q[0].op,
                      q[0].f3, q[0].f7, q[0].en, q[0].eb, q[0].ill}));
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && o32_valid) begin
         if (q32.size() == 0) begin
            chk("spurious_valid32", 256'(o32_valid), 256'(0));
         end else begin
            chk("bundle32", 256'({o32_imm, o32_fmt, o32_en_regw, o32_illegal}),
                256'({q32[0].imm, q32[0].fmt, q32[0].en, q32[0].ill}));
            void'(q32.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic   cap;
      int     idx;
      exp32_t e32;

      //        inst          rs1 rs2 rd  imm                     fmt op     f3 f7     en eb ill
      setv(0,  32'hFFF00093, 0,  31, 1,  64'hFFFFFFFFFFFFFFFF,   1, 7'h13, 0, 7'h7F, 1, 0, 0);
      setv(1,  32'hFE000EE3, 0,  0,  29, 64'hFFFFFFFFFFFFFFFC,   3, 7'h63, 0, 7'h7F, 0, 0, 0);
      setv(2,  32'h800002B7, 0,  0,  5,  64'hFFFFFFFF80000000,   4, 7'h37, 0, 7'h40, 1, 0, 0);
      setv(3,  32'h00000013, 0,  0,  0,  64'h0,                  1, 7'h13, 0, 7'h00, 0, 0, 0);
      setv(4,  32'h00100073, 0,  1,  0,  64'h0,                  7, 7'h73, 0, 7'h00, 0, 1, 0);
      setv(5,  32'h00000000, 0,  0,  0,  64'h0,                  7, 7'h00, 0, 7'h00, 0, 0, 1);
      setv(6,  32'h00000073, 0,  0,  0,  64'h0,                  7, 7'h73, 0, 7'h00, 0, 0, 1);
      setv(7,  32'h0010809B, 1,  1,  1,  64'h1,                  1, 7'h1B, 0, 7'h00, 1, 0, 0);
      setv(8,  32'h0020A423, 1,  2,  8,  64'h8,                  2, 7'h23, 2, 7'h00, 0, 0, 0);
      setv(9,  32'h008000EF, 0,  8,  1,  64'h8,                  5, 7'h6F, 0, 7'h00, 1, 0, 0);
      setv(10, 32'h002081B3, 1,  2,  3,  64'h0,                  0, 7'h33, 0, 7'h00, 1, 0, 0);
      setv(11, 32'h00002063, 0,  0,  0,  64'h0,                  3, 7'h63, 2, 7'h00, 0, 0, 1);

      i32_valid = 1'b0;
      i32_inst  = '0;
      i32_pc    = 32'h1000;

      drive_cycle(0, 0, 1, 0, 1, cap);
      drive_cycle(0, 0, 1, 0, 1, cap);
      chk_reset_state();

      // back-to-back decode of every vector
      for (int i = 0; i < 12; i++) drive_cycle(1, i, 1, 0, 0, cap);
      drive_cycle(0, 0, 1, 0, 0, cap);

      // backpressure: IFU holds each instruction until it is captured
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         drive_cycle(idx < 6, idx, !(c >= 1 && c <= 4), 0, 0, cap);
         if (cap) idx++;
      end
      chk("stream_complete", 256'(idx), 256'(6));

      // flush while stalled, then flush together with out_ready
      drive_cycle(1, 5, 0, 0, 0, cap);
      drive_cycle(1, 6, 0, 1, 0, cap);
      drive_cycle(0, 0, 0, 0, 0, cap);
      drive_cycle(1, 7, 0, 0, 0, cap);
      drive_cycle(1, 8, 1, 1, 0, cap);
      drive_cycle(0, 0, 1, 0, 0, cap);

      // reset in the middle of a stall
      drive_cycle(1, 9, 0, 0, 0, cap);
      drive_cycle(1, 10, 0, 0, 0, cap);
      drive_cycle(1, 10, 0, 0, 1, cap);
      chk_reset_state();
      drive_cycle(1, 0, 1, 0, 0, cap);
      drive_cycle(0, 0, 1, 0, 0, cap);

      // XLEN=32 instance: addiw is illegal, addi -1 extends only to 32 bits
      i32_valid = 1'b1;
      i32_inst  = 32'h0000001B;
      e32.imm = 32'h0; e32.fmt = 3'd1; e32.en = 1'b0; e32.ill = 1'b1;
      q32.push_back(e32);
      drive_cycle(0, 0, 1, 0, 0, cap);
      i32_inst  = 32'hFFF00093;
      e32.imm = 32'hFFFFFFFF; e32.fmt = 3'd1; e32.en = 1'b1; e32.ill = 1'b0;
      q32.push_back(e32);
      drive_cycle(0, 0, 1, 0, 0, cap);
      i32_valid = 1'b0;
      drive_cycle(0, 0, 1, 0, 0, cap);
      drive_cycle(0, 0, 1, 0, 0, cap);

      chk("queue_drained", 256'(q.size()), 256'(0));
      chk("queue32_drained", 256'(q32.size()), 256'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22041461_idu_stage.md
# ysyx_22041461_idu_stage

Registered instruction-decode stage for the NPC core, the pipelined successor to the single-instruction combinational decoder. It sits between IFU and EXU and accepts one fetched instruction per valid/ready handshake. It decodes the RV32I/RV64I base integer set into register indices, a sign-extended immediate, a format code and control flags, and presents the result from an output pipeline register. Stall and flush are supported; ebreak and illegal encodings are flagged to the downstream stage.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64. The OP-IMM-32 and OP-32 opcodes are legal only when XLEN=64.
- PC_W, 64, program-counter width.

- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard the held and incoming instruction (redirect from EXU)
- in_valid  in  1  IFU presents an instruction
- in_ready  out  1  stage can capture this cycle
- in_inst  in  32  instruction word
- in_pc  in  PC_W  PC of in_inst
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EXU accepts the bundle
- out_pc  out  PC_W  registered copy of in_pc
- out_rs1, out_rs2, out_rd  out  5 each  inst[19:15], inst[24:20], inst[11:7]
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none
- out_opcode  out  7  inst[6:0]
- out_funct3  out  3  inst[14:12]
- out_funct7  out  7  inst[31:25]
- out_en_regw  out  1  register write enable
- out_is_ebreak  out  1  inst == 0x00100073
- out_illegal  out  1  unsupported encoding

## Operation
- Combinational decode of in_inst selects the format from the opcode:
  - OP 0110011 and OP-32 0111011: R.
  - OP-IMM 0010011, OP-IMM-32 0011011, LOAD 0000011 and JALR 1100111: I.
  - STORE 0100011: S.
  - BRANCH 1100011: B.
  - LUI 0110111 and AUIPC 0010111: U.
  - JAL 1101111: J.
  - SYSTEM 1110011: none.
- Immediate construction, with sign bit inst[31] extended to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - R and none: 0.
- en_regw is 1 for R, I, U and J formats and 0 for S, B and SYSTEM. It is forced to 0 when rd == 0.
- illegal is 1 for any of the following:
  - an opcode not listed above;
  - an OP-32 or OP-IMM-32 opcode when XLEN=32;
  - SYSTEM with inst != 0x00100073;
  - BRANCH with funct3 of 010 or 011.
- When illegal=1, en_regw=0 and imm=0.
- Only the exact word 0x00100073 sets is_ebreak. That instruction has fmt=7 and en_regw=0.
- Pipeline register:
  - in_ready = !out_valid | out_ready.
  - A capture happens when in_valid & in_ready & !flush. On capture, all out_* fields load and out_valid <= 1.
  - When out_valid & out_ready and there is no capture, out_valid <= 0.
  - When out_valid & !out_ready, all out_* fields hold stable (stall).
- Flush has priority over everything except reset. With flush=1, out_valid <= 0 next cycle and no capture occurs regardless of in_valid.

## Timing
- Latency is 1 cycle: an instruction captured at edge N appears with out_valid=1 after edge N.
- Throughput is 1 instruction/cycle while out_ready=1. There is no bubble on back-to-back transfers because in_ready combinationally follows out_ready.
- Reset:
  - out_valid=0.
  - All out_* data fields are 0.
  - in_ready=1 in the cycle after reset.
  - Reset asserted mid-stall drops the held bundle.
- Simultaneous events:
  - Accept plus capture in the same cycle replaces the bundle and leaves out_valid=1.
  - Flush plus out_ready in the same cycle clears the bundle with no new capture.
- out_* data fields are don't-care when out_valid=0; the bench checks them only under out_valid.
- There is no combinational path from in_inst to any out_* field.

## Test plan
- addi x1,x0,-1 (0xFFF00093), XLEN=64 -> one cycle later out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFFFFFFFFFF, fmt=1, en_regw=1, illegal=0.
- Three decode cases:
  - beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFFFFFFFFFC, fmt=3, en_regw=0.
  - lui x5,0x80000 (0x800002B7) -> imm=0xFFFFFFFF80000000, fmt=4, en_regw=1.
  - addi x0,x0,0 (0x00000013) -> en_regw=0.
- Special encodings:
  - 0x00100073 -> is_ebreak=1, en_regw=0, illegal=0.
  - 0x00000000 and ecall 0x00000073 -> illegal=1, imm=0.
  - XLEN=32 with addiw 0x0000001B -> illegal=1.
- Backpressure: hold out_ready=0 for 4 cycles while in_valid=1 with a new instruction each cycle -> in_ready=0, out_* stable, no instruction lost or duplicated. Release -> the stream resumes in order.
- Flush: assert flush with out_valid=1 and in_valid=1 -> out_valid=0 the next cycle and the incoming instruction is dropped. Flush plus out_ready in the same cycle -> no capture.
- Reset: assert rst during a stall -> out_valid=0 and all fields 0 after the edge. The first post-reset instruction decodes correctly.
